// File: rtl/bird_motion_ctrl.sv
// rtl/bird_motion_ctrl.sv - per-frame bird position sequencer with IDLE/PLAYING/DEAD game FSM
module bird_motion_ctrl #(
    parameter int START_Y  = 236,
    parameter int FLOOR_Y  = 475,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int MAX_FALL = 7,
    parameter int VEL_W    = 6
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic                    frame_tick,
    input  logic                    flap,
    input  logic                    start,
    input  logic                    collide,
    output logic [31:0]             bird_y,
    output logic signed [VEL_W-1:0] bird_vel,
    output logic                    playing,
    output logic                    game_over
);

    typedef enum logic [1:0] {IDLE, PLAYING, DEAD} state_t;

    localparam logic [9:0]              START_W = 10'(START_Y);
    localparam logic [9:0]              FLOOR_P = 10'(FLOOR_Y);
    localparam logic signed [11:0]      FLOOR_W = 12'(FLOOR_Y);
    localparam logic signed [VEL_W:0]   GRAV_W  = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   MAXF_W  = (VEL_W+1)'(MAX_FALL);
    localparam logic signed [VEL_W-1:0] FLAP_W  = VEL_W'(FLAP_VEL);

    state_t                  state;
    logic [9:0]              y_q;
    logic                    flap_prev;
    logic                    flap_pend;

    logic                    flap_edge;
    logic                    flap_now;
    logic signed [VEL_W:0]   vel_inc;
    logic signed [VEL_W-1:0] vel_n;
    logic signed [11:0]      y_n;

    assign bird_y = {22'b0, y_q};

    // An edge arriving on the tick cycle itself still counts for that frame.
    always_comb begin
        flap_edge = flap & ~flap_prev;
        flap_now  = flap_pend | flap_edge;
        vel_inc   = {bird_vel[VEL_W-1], bird_vel} + GRAV_W;
        if (flap_now)
            vel_n = FLAP_W;
        else if (vel_inc > MAXF_W)
            vel_n = MAXF_W[VEL_W-1:0];
        else
            vel_n = vel_inc[VEL_W-1:0];
        y_n = $signed({2'b00, y_q}) + {{(12-VEL_W){vel_n[VEL_W-1]}}, vel_n};
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            y_q       <= START_W;
            bird_vel  <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            flap_prev <= 1'b0;
            flap_pend <= 1'b0;
        end else begin
            flap_prev <= flap;
            case (state)
                IDLE: begin
                    y_q       <= START_W;
                    bird_vel  <= '0;
                    flap_pend <= 1'b0;
                    if (start) begin
                        state   <= PLAYING;
                        playing <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (frame_tick) begin
                        flap_pend <= 1'b0;
                        if (y_n < 0) begin
                            // Ceiling is a hard stop, not a death.
                            y_q      <= '0;
                            bird_vel <= '0;
                        end else if (y_n >= FLOOR_W) begin
                            y_q      <= FLOOR_P;
                            bird_vel <= vel_n;
                        end else begin
                            y_q      <= y_n[9:0];
                            bird_vel <= vel_n;
                        end
                        if (collide || (y_n >= FLOOR_W)) begin
                            state     <= DEAD;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end
                    end else if (flap_edge) begin
                        flap_pend <= 1'b1;
                    end
                end
                DEAD: begin
                    flap_pend <= 1'b0;
                    if (start) begin
                        state     <= IDLE;
                        y_q       <= START_W;
                        bird_vel  <= '0;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb/tb_bird_motion_ctrl.sv - directed scoreboard bench for bird_motion_ctrl
module tb_bird_motion_ctrl;

    logic              clock = 1'b0;
    logic              reset_L;
    logic              frame_tick;
    logic              flap;
    logic              start;
    logic              collide;
    logic [31:0]       bird_y;
    logic signed [5:0] bird_vel;
    logic              playing;
    logic              game_over;

    bird_motion_ctrl dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .frame_tick (frame_tick),
        .flap       (flap),
        .start      (start),
        .collide    (collide),
        .bird_y     (bird_y),
        .bird_vel   (bird_vel),
        .playing    (playing),
        .game_over  (game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        int y;
        int vel;
        bit pl;
        bit go;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference game model: 0 idle, 1 playing, 2 dead.
    int   m_st, m_y, m_vel;
    bit   m_pend;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.y   = m_y;
        e.vel = m_vel;
        e.pl  = (m_st == 1);
        e.go  = (m_st == 2);
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_y"},    int'(bird_y),          e.y);
        chk({tag, "_vel"},  int'(bird_vel),        e.vel);
        chk({tag, "_play"}, int'(playing),         int'(e.pl));
        chk({tag, "_over"}, int'(game_over),       int'(e.go));
    endtask

    task automatic model_tick(input bit col);
        int  v, ny;
        bit  dead;
        if (m_st == 1) begin
            if (m_pend)           v = -8;
            else if (m_vel >= 6)  v = 7;
            else                  v = m_vel + 1;
            ny = m_y + v;
            if (ny < 0) begin
                ny = 0;
                v  = 0;
            end
            dead = col;
            if (ny >= 475) begin
                ny   = 475;
                dead = 1'b1;
            end
            m_y    = ny;
            m_vel  = v;
            m_pend = 1'b0;
            if (dead) m_st = 2;
        end
    endtask

    task automatic model_start();
        if (m_st == 0) begin
            m_st   = 1;
            m_vel  = 0;
            m_pend = 1'b0;
        end else if (m_st == 2) begin
            m_st  = 0;
            m_y   = 236;
            m_vel = 0;
        end
    endtask

    task automatic do_tick(input bit col, input string tag);
        @(negedge clock);
        frame_tick = 1'b1;
        collide    = col;
        model_tick(col);
        push_exp();
        @(negedge clock);
        frame_tick = 1'b0;
        collide    = 1'b0;
        check_out(tag);
    endtask

    task automatic do_start(input string tag);
        @(negedge clock);
        start = 1'b1;
        model_start();
        push_exp();
        @(negedge clock);
        start = 1'b0;
        check_out(tag);
    endtask

    task automatic do_flap();
        @(negedge clock);
        flap = 1'b1;
        if (m_st == 1) m_pend = 1'b1;
        @(negedge clock);
        flap = 1'b0;
    endtask

    initial begin
        reset_L    = 1'b0;
        frame_tick = 1'b0;
        flap       = 1'b0;
        start      = 1'b0;
        collide    = 1'b0;
        m_st = 0; m_y = 236; m_vel = 0; m_pend = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        push_exp();
        check_out("reset");
        reset_L = 1'b1;

        // start together with frame_tick: transition only, no motion
        @(negedge clock);
        start      = 1'b1;
        frame_tick = 1'b1;
        model_start();
        push_exp();
        @(negedge clock);
        start      = 1'b0;
        frame_tick = 1'b0;
        check_out("start_tick");

        do_tick(1'b0, "fall1");
        do_tick(1'b0, "fall2");
        do_tick(1'b0, "fall3");
        chk("fall3_y_const",   int'(bird_y),   242);
        chk("fall3_vel_const", int'(bird_vel), 3);

        for (int i = 0; i < 60 && m_st == 1; i++) do_tick(1'b0, "freefall");
        chk("floor_reached", m_st, 2);
        chk("floor_y_const",   int'(bird_y),    475);
        chk("floor_over_const", int'(game_over), 1);

        do_flap();
        do_tick(1'b0, "dead_frozen");
        do_start("dead_to_idle");
        do_start("idle_to_play");

        do_flap();
        do_flap();
        do_tick(1'b0, "dbl_flap");
        chk("dbl_flap_y_const",   int'(bird_y),   228);
        chk("dbl_flap_vel_const", int'(bird_vel), -8);
        do_tick(1'b0, "after_flap");
        chk("after_flap_y_const", int'(bird_y), 221);

        for (int i = 0; i < 40 && m_y != 0; i++) begin
            do_flap();
            do_tick(1'b0, "climb");
        end
        do_flap();
        do_tick(1'b0, "ceiling");
        chk("ceiling_y_const",    int'(bird_y),    0);
        chk("ceiling_vel_const",  int'(bird_vel),  0);
        chk("ceiling_play_const", int'(playing),   1);

        do_tick(1'b0, "pre_collide");
        do_tick(1'b1, "collide");
        chk("collide_y_const", int'(bird_y), 3);
        do_flap();
        do_tick(1'b0, "collide_frozen");
        do_start("collide_restart");

        // asynchronous reset mid-frame with a flap pending
        do_start("play_again");
        do_tick(1'b0, "pre_reset");
        do_flap();
        @(negedge clock);
        #2 reset_L = 1'b0;
        #1;
        m_st = 0; m_y = 236; m_vel = 0; m_pend = 1'b0;
        push_exp();
        check_out("async_reset");
        @(negedge clock);
        reset_L = 1'b1;
        do_start("post_reset_start");
        do_tick(1'b0, "post_reset_tick");
        chk("post_reset_vel_const", int'(bird_vel), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
- Sequences the bird's vertical position once per video frame and drives the 32-bit bird_y bus consumed by the pixel colour logic.
- Owns the game-state FSM (IDLE/PLAYING/DEAD), applies gravity and flap impulses, clamps to the playfield, and flags floor collisions.
- bird_y changes only on the frame tick, so it is stable for the whole active video region.

Parameters:
- START_Y, 236, bird_y loaded on reset and on every start.
- FLOOR_Y, 475, largest legal bird_y (the 5-px sprite bottom reaches row 479); reaching it ends the game.
- GRAVITY, 1, velocity increment per frame in px/frame.
- FLAP_VEL, -8, signed velocity loaded on a flap (negative means upward).
- MAX_FALL, 7, terminal downward velocity in px/frame.
- VEL_W, 6, velocity register width, two's complement.

Ports:
- clock  input  1  system clock
- reset_L  input  1  asynchronous active-low reset
- frame_tick  input  1  one-cycle pulse at the start of vertical blanking
- flap  input  1  synchronised button level; a rising edge requests a flap
- start  input  1  level; starts or restarts the game
- collide  input  1  pipe-collision flag from the obstacle logic, sampled only on frame_tick
- bird_y  output  32  bird top row, zero-extended; bits [31:10] are always 0
- bird_vel  output  VEL_W  current signed velocity
- playing  output  1  high in PLAYING
- game_over  output  1  high in DEAD

Behaviour:
- Reset (asynchronous, while reset_L=0):
  - state=IDLE, bird_y=START_Y, bird_vel=0, playing=0, game_over=0.
  - The flap edge register and the pending-flap latch are cleared.
- Flap capture:
  - flap_prev is registered every cycle.
  - A rising edge (flap & ~flap_prev) sets flap_pend.
  - flap_pend clears on the cycle a frame update consumes it.
  - An edge in the same cycle as frame_tick counts for that frame.
  - Multiple edges within one frame count as one flap.
- IDLE:
  - bird_y holds at START_Y and bird_vel holds at 0.
  - On start=1, go to PLAYING next cycle, bird_vel=0, and clear flap_pend.
- PLAYING, on frame_tick only (all other cycles hold):
  - Velocity: if flap_pend, vel_n=FLAP_VEL. Otherwise vel_n=min(vel+GRAVITY, MAX_FALL).
  - Position: y_n = bird_y + vel_n, computed in at least 12-bit signed arithmetic.
  - If y_n < 0: bird_y=0 and bird_vel=0 (ceiling clamp, not a death).
  - If y_n >= FLOOR_Y: bird_y=FLOOR_Y and go to DEAD.
  - If collide=1 on the tick: apply the position update, then go to DEAD.
  - Registered outputs become visible the cycle after frame_tick (latency 1).
- DEAD:
  - bird_y and bird_vel freeze and game_over=1.
  - frame_tick and flap are ignored.
  - start=1 returns to IDLE next cycle with bird_y=START_Y and bird_vel=0. Holding start therefore yields IDLE, then PLAYING on the following cycle.
- Simultaneous events:
  - start and frame_tick together in IDLE: the transition to PLAYING wins; no motion occurs that tick.
  - Floor hit and collide on the same tick: DEAD, with bird_y clamped to FLOOR_Y.
- Reset mid-game: an immediate return to the reset values, regardless of the clock.
- Widths:
  - bird_y[9:0] never exceeds FLOOR_Y.
  - bird_vel never exceeds MAX_FALL and never goes below FLAP_VEL.

Test Plan:
- Reset, then start, then 3 frame_ticks with no flap -> bird_vel 1,2,3; bird_y 237,239,242; playing=1.
- Free-fall until vel saturates -> bird_vel stays at 7; bird_y increases by 7 per tick; the tick that reaches y>=475 gives bird_y=475, game_over=1, playing=0.
- In PLAYING with bird_y=236, pulse flap twice in one frame, then tick -> bird_vel=-8, bird_y=228; next tick with no flap gives vel=-7, bird_y=221.
- Flap repeatedly from bird_y=5 -> bird_y=0 and bird_vel=0; still playing; no game_over.
- collide=1 asserted on a tick with bird_y=100, vel=2 -> bird_y=103 and DEAD; further ticks and flaps leave bird_y=103; start gives bird_y=236 and IDLE.
- Deassert reset_L mid-frame while PLAYING -> outputs reset asynchronously (bird_y=236, flags 0); flap_pend is cleared so the first tick after restart applies gravity.
